// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Latency: none (constants only).
// Backpressure: not applicable.
package fetch_unit_pkg;

  // Fetch state encoding: BOOT is a single bubble after reset, RUN fetches, HALTED drains only.
  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // Instruction presented to decode when nothing is buffered.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Default PC after reset and per-fetch increment.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          DEFAULT_PC_STEP  = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, instr} entries between fetch and decode.
// Latency: a pushed entry is visible at the head on the cycle after the push.
// Backpressure: caller must only push when not full or when popping the same cycle; flush wins.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             pop_ok;

  // A pop on an empty FIFO is meaningless, so it is dropped here.
  assign pop_ok = pop && (count != '0);
  assign head   = mem[rd_ptr];

  // Storage write; pointers are what make an entry live, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking; flush discards everything like a reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, fetches from a combinational IM and buffers {pc, instr} for decode.
// Latency: one cycle from fetch to the entry appearing on instr_out; one bubble cycle after reset.
// Backpressure: id_ready low stalls the FIFO; fetch pauses when full unless the head is popped.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              INSTR_W  = 32,
  parameter int              DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int              PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               instr_valid,
  input  logic               id_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic               halted
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + INSTR_W;

  logic [1:0]          state;
  logic [ADDR_W-1:0]   pc;
  logic [CNT_W-1:0]    count;
  logic [ENT_W-1:0]    head;
  logic                pop;
  logic                push;
  logic                redirect;
  logic                not_empty;

  // BOOT ignores redirects entirely; elsewhere a redirect flushes and reloads the PC.
  assign redirect  = redirect_valid && (state != ST_BOOT);
  assign not_empty = (count != '0);
  assign pop       = not_empty && id_ready;
  assign push      = (state == ST_RUN) && !redirect_valid &&
                     ((count < CNT_W'(DEPTH)) || pop);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({pc, imem_instr}),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .count     (count)
  );

  assign imem_addr   = pc;
  assign instr_valid = not_empty;
  assign instr_out   = not_empty ? head[INSTR_W-1:0] : INSTR_W'(NOP_INSTR);
  assign pc_out      = not_empty ? head[ENT_W-1:INSTR_W] : '0;
  assign halted      = (state == ST_HALTED);

  // PC register: redirect target is word-aligned; otherwise advance on every accepted fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_pc & ~ADDR_W'(3);
    end else if (push) begin
      pc <= pc + ADDR_W'(PC_STEP);
    end
  end

  // Fetch FSM: redirect has priority over halt, and a halt still lets that cycle's fetch land.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_BOOT;
    end else begin
      case (state)
        ST_BOOT:   state <= ST_RUN;
        ST_RUN:    if (!redirect_valid && halt_req) state <= ST_HALTED;
        ST_HALTED: if (redirect_valid) state <= ST_RUN;
        default:   state <= ST_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a queue-based model predicts fetched entries and outputs.
// Latency: model entries become visible one cycle after the edge that fetched them.
// Backpressure: id_ready, redirect, halt and reset are driven directly and randomly.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        halted;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .instr_out      (instr_out),
    .pc_out         (pc_out),
    .instr_valid    (instr_valid),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  // Instruction memory: each word is its address xor a fixed pattern.
  assign imem_instr = imem_addr ^ 32'hA5A5_0000;

  typedef enum {M_BOOT, M_RUN, M_HALT} mode_t;

  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  mode_t       m_mode;
  logic [31:0] m_pc;
  logic [63:0] m_fifo[$];
  logic [63:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: advance one clock using the inputs the DUT just sampled.
  task automatic model_step();
    bit popping;
    bit pushing;
    logic [63:0] ent;
    if (rst) begin
      m_pc   = 32'h0;
      m_mode = M_BOOT;
      m_fifo.delete();
      exp_q.delete();
    end else if (m_mode == M_BOOT) begin
      m_mode = M_RUN;
    end else if (redirect_valid) begin
      m_fifo.delete();
      exp_q.delete();
      m_pc   = {redirect_pc[31:2], 2'b00};
      m_mode = M_RUN;
    end else begin
      popping = (m_fifo.size() > 0) && id_ready;
      pushing = (m_mode == M_RUN) && ((m_fifo.size() < 2) || popping);
      if (popping) void'(m_fifo.pop_front());
      if (pushing) begin
        ent = {m_pc, m_pc ^ 32'hA5A5_0000};
        m_fifo.push_back(ent);
        exp_q.push_back(ent);
        m_pc = m_pc + 32'd4;
      end
      if (m_mode == M_RUN && halt_req) m_mode = M_HALT;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic r, input logic rdy, input logic rv,
                       input logic [31:0] rpc, input logic h);
    rst            = r;
    id_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt_req       = h;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: compares DUT outputs with the model, popping expected entries as decode accepts them.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("instr_valid", {63'd0, instr_valid}, {63'd0, m_fifo.size() != 0});
        chk("imem_addr", {32'd0, imem_addr}, {32'd0, m_pc});
        chk("halted", {63'd0, halted}, {63'd0, m_mode == M_HALT});
        if (instr_valid) begin
          if (exp_q.size() != 0) begin
            chk("head_pc_instr", {pc_out, instr_out}, exp_q[0]);
            if (id_ready) void'(exp_q.pop_front());
          end
        end else begin
          chk("empty_head", {pc_out, instr_out}, 64'd0);
        end
      end
    end
  end

  initial begin
    int waited;
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    mon_en = 1'b1;
    tick();

    // Free-running fetch with decode always ready.
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    ticks(10);

    // Stall decode from the start: FIFO fills, then release for sustained push+pop.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    ticks(6);
    id_ready = 1'b1;
    ticks(8);

    // Redirect with two entries buffered; low address bits must be dropped.
    id_ready = 1'b0;
    ticks(3);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0103, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    ticks(5);

    // Halt at PC 0x10, drain, then restart with a redirect to 0x40.
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    waited = 0;
    while (imem_addr != 32'h10 && waited < 50) begin
      tick();
      waited++;
    end
    chk("reach_pc10", {32'd0, imem_addr}, 64'h10);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    id_ready = 1'b0;
    ticks(2);
    id_ready = 1'b1;
    ticks(5);
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0040, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    ticks(4);

    // Redirect together with halt: redirect wins, fetch continues.
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF6, 1'b1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    ticks(4);

    // Reset mid-stream, with redirect and halt asserted during the BOOT bubble.
    id_ready = 1'b0;
    ticks(2);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 32'h0000_0800, 1'b1);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    ticks(4);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom_range(0, 149) == 0);
      id_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 1) == 0) ? $urandom()
                                                   : (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)));
      halt_req       = ($urandom_range(0, 24) == 0);
      tick();
    end

    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    ticks(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
